data_mem_lsu: RTL

//   Parametrised successor to the core's flat word data memory: RV32 load/store unit plus word SRAM.

---
 rtl/data_mem_lsu_pkg.sv | 47 ++++
 rtl/data_mem_lsu_if.sv | 29 ++
 rtl/data_mem_lsu_align.sv | 73 +++++++
 rtl/data_mem_lsu.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/data_mem_lsu_pkg.sv
// Shared definitions for the data memory load/store unit: RV32 funct3
// codes, access-size decoding and the LSU FSM state encoding.
package data_mem_lsu_pkg;

  localparam int XLEN = 32;

  // Load funct3 codes
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_BAD  = 2'd3
  } lsu_size_t;

  // Stores only know SB/SH/SW; the unsigned load codes are illegal for them.
  function automatic lsu_size_t decode_size(input logic is_store, input logic [2:0] funct3);
    lsu_size_t size;
    size = SIZE_BAD;
    case (funct3)
      FUNCT3_LB:  size = SIZE_BYTE;
      FUNCT3_LH:  size = SIZE_HALF;
      FUNCT3_LW:  size = SIZE_WORD;
      FUNCT3_LBU: size = is_store ? SIZE_BAD : SIZE_BYTE;
      FUNCT3_LHU: size = is_store ? SIZE_BAD : SIZE_HALF;
      default:    size = SIZE_BAD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the core and the data memory LSU.
// The core drives the request side (master); the LSU answers (slave).
interface data_mem_lsu_if
  import data_mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/data_mem_lsu_align.sv
// lsu_align: combinational lane steering for the LSU.
// Store side turns rs2 data into a byte-lane mask plus replicated data;
// load side picks the addressed lanes out of a memory word and extends them.
// Optional feature: `LSU_MISALIGN_TRAP_EN makes misaligned half/word
// accesses an error; otherwise the low address bits are ignored for them.
module lsu_align
  import data_mem_lsu_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] mem_word,
  output logic [3:0]      wr_mask,
  output logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] load_data,
  output logic            err
);

  lsu_size_t   size;
  logic        misalign;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Decode the access, flag errors, then steer lanes; an error suppresses both write and data.
  always_comb begin
    size = decode_size(we, funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((size == SIZE_HALF) && addr_lo[0]) ||
               ((size == SIZE_WORD) && (addr_lo != 2'b00));
`else
    misalign = 1'b0;
`endif
    err       = (size == SIZE_BAD) || misalign;
    sel_byte  = mem_word[{addr_lo, 3'b000} +: 8];
    sel_half  = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    wr_mask   = 4'b0000;
    wr_data   = '0;
    load_data = '0;
    if (!err) begin
      if (we) begin
        case (size)
          SIZE_BYTE: begin
            wr_mask = 4'b0001 << addr_lo;
            wr_data = {4{wdata[7:0]}};
          end
          SIZE_HALF: begin
            wr_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{wdata[15:0]}};
          end
          SIZE_WORD: begin
            wr_mask = 4'b1111;
            wr_data = wdata;
          end
          default: begin
            wr_mask = 4'b0000;
            wr_data = '0;
          end
        endcase
      end else begin
        case (size)
          SIZE_BYTE: load_data = funct3[2] ? {24'b0, sel_byte}
                                           : {{24{sel_byte[7]}}, sel_byte};
          SIZE_HALF: load_data = funct3[2] ? {16'b0, sel_half}
                                           : {{16{sel_half[15]}}, sel_half};
          SIZE_WORD: load_data = mem_word;
          default:   load_data = '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: RV32 load/store unit with an on-chip word SRAM.
// One request at a time over a valid/ready bus; each access spends
// WAIT_STATES cycles in BUSY, commits on the edge into RESP and reports
// through a one-cycle resp_valid pulse.
// Optional feature: `LSU_MISALIGN_TRAP_EN (misaligned half/word -> resp_err).
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
)
(
  input logic           clk,
  input logic           reset,
  data_mem_lsu_if.slave bus
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAST_CNT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  lsu_state_t       state;
  logic [2:0]       wait_cnt;
  logic             lat_we;
  logic [2:0]       lat_funct3;
  logic [IDX_W-1:0] lat_idx;
  logic [1:0]       lat_lo;
  logic [XLEN-1:0]  lat_wdata;

  logic             cur_we;
  logic [2:0]       cur_funct3;
  logic [IDX_W-1:0] cur_idx;
  logic [1:0]       cur_lo;
  logic [XLEN-1:0]  cur_wdata;
  logic             commit;

  logic [XLEN-1:0]  mem [DEPTH_WORDS];
  logic [XLEN-1:0]  mem_word;
  logic [3:0]       wr_mask;
  logic [XLEN-1:0]  wr_data;
  logic [XLEN-1:0]  load_data;
  logic             align_err;

  // Address bits above the word index alias onto the same SRAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr;

  // With no wait states the access commits on the accepting edge, so it must use the live bus.
  always_comb begin
    if (state == LSU_IDLE) begin
      cur_we     = bus.req_we;
      cur_funct3 = bus.req_funct3;
      cur_idx    = bus.req_addr[IDX_W+1:2];
      cur_lo     = bus.req_addr[1:0];
      cur_wdata  = bus.req_wdata;
    end else begin
      cur_we     = lat_we;
      cur_funct3 = lat_funct3;
      cur_idx    = lat_idx;
      cur_lo     = lat_lo;
      cur_wdata  = lat_wdata;
    end
  end

  assign commit = ((state == LSU_IDLE) && bus.req_valid && (WAIT_STATES == 0)) ||
                  ((state == LSU_BUSY) && (wait_cnt == LAST_CNT));

  assign mem_word = mem[cur_idx];

  lsu_align u_align (
    .we        (cur_we),
    .funct3    (cur_funct3),
    .addr_lo   (cur_lo),
    .wdata     (cur_wdata),
    .mem_word  (mem_word),
    .wr_mask   (wr_mask),
    .wr_data   (wr_data),
    .load_data (load_data),
    .err       (align_err)
  );

  // Request FSM with wait counter, request latch and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= LSU_IDLE;
      wait_cnt       <= 3'd0;
      lat_we         <= 1'b0;
      lat_funct3     <= 3'd0;
      lat_idx        <= '0;
      lat_lo         <= 2'd0;
      lat_wdata      <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (bus.req_valid) begin
            lat_we        <= bus.req_we;
            lat_funct3    <= bus.req_funct3;
            lat_idx       <= bus.req_addr[IDX_W+1:2];
            lat_lo        <= bus.req_addr[1:0];
            lat_wdata     <= bus.req_wdata;
            wait_cnt      <= 3'd0;
            bus.req_ready <= 1'b0;
            state         <= (WAIT_STATES == 0) ? LSU_RESP : LSU_BUSY;
          end
        end
        LSU_BUSY: begin
          if (wait_cnt == LAST_CNT) begin
            state <= LSU_RESP;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        LSU_RESP: begin
          state         <= LSU_IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= LSU_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
      if (commit) begin
        bus.resp_valid <= 1'b1;
        bus.resp_rdata <= load_data;
        bus.resp_err   <= align_err;
      end
    end
  end

  // Word SRAM: cleared by reset, byte lanes written on the commit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          mem[cur_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule
